// File: rtl/div_pkg.sv
// Shared definitions for the divider result path.
//   MANT_W_DEF / OUT_W_DEF / SHIFT_W_DEF : default widths of the mantissa,
//                                         the signed result and the signed shift
//   shift_t                              : signed net-shift type (>0 right, <0 left)
//   MAX_POS / MAX_NEG                    : saturation values of the default-width result
package div_pkg;

  localparam int unsigned MANT_W_DEF  = 64;
  localparam int unsigned OUT_W_DEF   = 64;
  localparam int unsigned SHIFT_W_DEF = 8;

  typedef logic signed [SHIFT_W_DEF-1:0] shift_t;

  localparam logic [OUT_W_DEF-1:0] MAX_POS = {1'b0, {(OUT_W_DEF-1){1'b1}}};
  localparam logic [OUT_W_DEF-1:0] MAX_NEG = {1'b1, {(OUT_W_DEF-1){1'b0}}};

endpackage

// File: rtl/sticky_right_shifter.sv
// Combinational logical right shift that keeps rounding information.
//   data   : unsigned value to shift
//   amt    : unsigned shift amount
//   mag    : data >> amt
//   guard  : first bit shifted out
//   sticky : OR of every bit shifted out below the guard bit
// Shifts larger than IN_W push every bit past the guard position, so the
// whole input collapses into sticky.
module sticky_right_shifter #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned AMT_W = 8
) (
  input  logic [IN_W-1:0]  data,
  input  logic [AMT_W-1:0] amt,
  output logic [IN_W-1:0]  mag,
  output logic             guard,
  output logic             sticky
);

  logic [2*IN_W-1:0] wide;

  always_comb begin
    // Upper half becomes the magnitude, lower half holds the discarded bits.
    wide = {data, {IN_W{1'b0}}} >> amt;
    if (32'(amt) > IN_W) begin
      mag    = '0;
      guard  = 1'b0;
      sticky = |data;
    end else begin
      mag    = wide[2*IN_W-1:IN_W];
      guard  = wide[IN_W-1];
      sticky = |wide[IN_W-2:0];
    end
  end

endmodule

// File: rtl/quotient_denormalizer.sv
// Undoes the divider's input normalization: shifts the normalized quotient
// mantissa back to the output Q format, rounds to nearest-even, applies the
// sign and saturates. Two-stage elastic pipeline (shift, then round/sign/sat).
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : input beat valid            in_ready  : input beat accepted
//   in_mant      : normalized unsigned mantissa
//   in_shift     : signed shift, >0 right, <0 left
//   in_neg       : result is negative
//   out_valid    : output beat valid           out_ready : downstream accepts
//   out_data     : signed two's-complement result
//   out_ovf      : result saturated
//   out_inexact  : nonzero bits were discarded by rounding
module quotient_denormalizer
  import div_pkg::*;
#(
  parameter int unsigned MANT_W  = MANT_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter int unsigned SHIFT_W = SHIFT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MANT_W-1:0]  in_mant,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_neg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_ovf,
  output logic               out_inexact
);

  localparam int unsigned W  = (MANT_W > OUT_W) ? MANT_W : OUT_W;
  // Wide enough to hold the mantissa after the largest possible left shift.
  localparam int unsigned LW = MANT_W + OUT_W + (1 << SHIFT_W);

  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  // 2^(OUT_W-1): magnitude of the most negative result.
  localparam logic [OUT_W:0]   HALF    = {2'b01, {(OUT_W-1){1'b0}}};

  // Stage 1 registers
  logic             s1_valid;
  logic [OUT_W-1:0] s1_mag;
  logic             s1_g;
  logic             s1_s;
  logic             s1_pre_ovf;
  logic             s1_neg;

  logic s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Right-shift path
  logic [SHIFT_W-1:0] r_amt;
  logic [MANT_W-1:0]  r_mag;
  logic               r_g;
  logic               r_s;
  logic [W-1:0]       r_mag_w;

  assign r_amt = in_shift;

  sticky_right_shifter #(
    .IN_W  (MANT_W),
    .AMT_W (SHIFT_W)
  ) u_rshift (
    .data   (in_mant),
    .amt    (r_amt),
    .mag    (r_mag),
    .guard  (r_g),
    .sticky (r_s)
  );

  assign r_mag_w = W'(r_mag);

  // Left-shift path: negate with one extra bit so the most negative shift fits.
  logic [SHIFT_W:0] l_amt;
  logic [LW-1:0]    l_wide;

  assign l_amt  = '0 - {in_shift[SHIFT_W-1], in_shift};
  assign l_wide = LW'(in_mant) << l_amt;

  logic [OUT_W-1:0] n1_mag;
  logic             n1_g;
  logic             n1_s;
  logic             n1_pre_ovf;

  always_comb begin
    n1_mag     = '0;
    n1_g       = 1'b0;
    n1_s       = 1'b0;
    n1_pre_ovf = 1'b0;
    if (in_mant == '0) begin
      n1_mag = '0;
    end else if (!in_shift[SHIFT_W-1]) begin
      n1_mag     = r_mag_w[OUT_W-1:0];
      n1_g       = r_g;
      n1_s       = r_s;
      n1_pre_ovf = (r_mag_w >> OUT_W) != '0;
    end else begin
      n1_mag     = l_wide[OUT_W-1:0];
      n1_pre_ovf = ((l_wide >> OUT_W) != '0) || ({1'b0, l_wide[OUT_W-1:0]} > HALF);
    end
  end

  // Stage 2: round, sign, saturate
  logic             rnd;
  logic [OUT_W:0]   sum;
  logic [OUT_W-1:0] sum_lo;
  logic             sat;
  logic [OUT_W-1:0] n2_data;
  logic             n2_inexact;

  always_comb begin
    rnd    = s1_g && (s1_s || s1_mag[0]);
    sum    = {1'b0, s1_mag} + {{OUT_W{1'b0}}, rnd};
    sum_lo = sum[OUT_W-1:0];
    // A negative result may reach exactly 2^(OUT_W-1); a positive one may not.
    sat    = s1_pre_ovf || (s1_neg ? (sum > HALF) : (sum >= HALF));
    if (sat) begin
      n2_data = s1_neg ? SAT_NEG : SAT_POS;
    end else begin
      n2_data = s1_neg ? -sum_lo : sum_lo;
    end
    n2_inexact = (s1_g || s1_s) && !sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_mag      <= '0;
      s1_g        <= 1'b0;
      s1_s        <= 1'b0;
      s1_pre_ovf  <= 1'b0;
      s1_neg      <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mag     <= n1_mag;
          s1_g       <= n1_g;
          s1_s       <= n1_s;
          s1_pre_ovf <= n1_pre_ovf;
          s1_neg     <= in_neg;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data    <= n2_data;
          out_ovf     <= sat;
          out_inexact <= n2_inexact;
        end
      end
    end
  end

endmodule

// File: tb/tb_quotient_denormalizer.sv
// Scoreboard bench for quotient_denormalizer: expected results come from an
// exact-arithmetic reference (divide by a power of two, compare the remainder
// against one half, clamp to the signed range).
module tb_quotient_denormalizer;
  import div_pkg::*;

  localparam int unsigned MW = MANT_W_DEF;
  localparam int unsigned OW = OUT_W_DEF;
  localparam int unsigned SW = SHIFT_W_DEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] in_mant = '0;
  shift_t        in_shift = '0;
  logic          in_neg = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_ovf;
  logic          out_inexact;

  always #5 clk = ~clk;

  quotient_denormalizer #(
    .MANT_W  (MW),
    .OUT_W   (OW),
    .SHIFT_W (SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mant     (in_mant),
    .in_shift    (in_shift),
    .in_neg      (in_neg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .out_inexact (out_inexact)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic          ovf;
    logic          inexact;
    logic          lat;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   seen_head = 0;
  int   ready_mode = 0;
  int   pat_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Exact reference: value = m * 2^(-sh), rounded half-to-even, then clamped.
  function automatic exp_t model(input logic [MW-1:0] m, input int sh, input bit neg);
    exp_t          e;
    logic [255:0]  q;
    logic [255:0]  rem;
    logic [255:0]  half;
    logic [255:0]  lim;
    logic [OW-1:0] lo;
    bit            inex;
    e.data = '0; e.ovf = 1'b0; e.inexact = 1'b0; e.lat = 1'b0; e.cyc = 0;
    if (m == '0) return e;
    inex = 0;
    if (sh >= 0) begin
      q   = 256'(m) >> sh;
      rem = 256'(m) - (q << sh);
      if (rem != '0) begin
        inex = 1;
        half = 256'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 256'(1);
      end
    end else begin
      q = 256'(m) << (-sh);
    end
    lim = 256'(1) << (OW - 1);
    if ((neg && q > lim) || (!neg && q > lim - 256'(1))) begin
      e.data = neg ? MAX_NEG : MAX_POS;
      e.ovf  = 1'b1;
    end else begin
      lo        = q[OW-1:0];
      e.data    = neg ? -lo : lo;
      e.inexact = inex;
    end
    return e;
  endfunction

  function automatic logic next_ready();
    logic r;
    case (ready_mode)
      0:       r = 1'b1;
      1:       begin r = (pat_idx % 4 == 0) || (pat_idx % 4 == 3); pat_idx++; end
      2:       r = ($urandom_range(0, 3) != 0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Only both stages full with a stalled output may refuse a beat.
  task automatic check_ready();
    check("in_ready", OW'(in_ready), OW'(!(sb.size() == 2 && !out_ready)));
  endtask

  task automatic send(input logic [MW-1:0] m, input int sh, input bit neg);
    exp_t e;
    int   tries;
    bit   done;
    e     = model(m, sh, neg);
    tries = 0;
    done  = 0;
    while (!done) begin
      @(posedge clk); #2;
      out_ready = next_ready();
      in_valid  = 1'b1;
      in_mant   = m;
      in_shift  = shift_t'(sh);
      in_neg    = neg;
      #1;
      check_ready();
      if (in_ready) begin
        e.lat = (sb.size() == 0);
        e.cyc = cyc;
        sb.push_back(e);
        done = 1;
      end else if (++tries > 50) begin
        $display("FAIL send_timeout: in_ready stuck at %0d, expected 1 within 50 cycles", in_ready);
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      out_ready = next_ready();
      in_valid  = 1'b0;
      #1;
      check_ready();
    end
  endtask

  // Monitor: pops and compares on every output transfer.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #4;
      if (!rst && out_valid) begin
        if (sb.size() > 0 && !seen_head) begin
          seen_head = 1;
          if (sb[0].lat) check("latency", OW'(cyc - sb[0].cyc), OW'(2));
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_output: got %h, expected no beat", out_data);
          end else begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_ovf", OW'(out_ovf), OW'(e.ovf));
            check("out_inexact", OW'(out_inexact), OW'(e.inexact));
          end
          seen_head = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached with %0d beats pending", sb.size());
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1);
  end

  initial begin
    logic [MW-1:0] m;
    logic [MW-1:0] mask;
    logic [MW-1:0] one;
    int            sh;
    int            k;
    one = 1;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", OW'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ovf", OW'(out_ovf), '0);
    check("rst_out_inexact", OW'(out_inexact), '0);
    check("rst_in_ready", OW'(in_ready), OW'(1));

    ready_mode = 0;
    send(64'h8000_0000_0000_0000, 32, 1'b0);
    send(64'h8000_0000_0000_0003, 1, 1'b0);
    send(64'h8000_0000_0000_0001, 1, 1'b0);
    send(64'h8000_0000_0000_0000, 0, 1'b0);
    send(64'h8000_0000_0000_0000, 0, 1'b1);
    send(64'h8000_0000_0000_0000, -3, 1'b0);
    send(64'h0000_0000_0000_0000, -3, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1);
    send(64'hC000_0000_0000_0000, 64, 1'b1);
    send(64'h8000_0000_0000_0000, 64, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b1);
    send(64'h8000_0000_0000_0000, 127, 1'b0);
    send(64'h8000_0000_0000_0000, -128, 1'b1);
    send(64'h8000_0000_0000_0000, 63, 1'b1);
    idle(3);

    // Stream of 8 beats under a 1,0,0,1 out_ready pattern
    ready_mode = 1;
    pat_idx    = 0;
    for (int i = 0; i < 8; i++) begin
      m = {$urandom, $urandom};
      m[MW-1] = 1'b1;
      send(m, 8 + i, i[0]);
    end
    ready_mode = 0;
    idle(4);

    // Reset with both stages occupied
    ready_mode = 3;
    send(64'h8000_0000_0000_0000, 4, 1'b0);
    send(64'h9000_0000_0000_0000, 5, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    sb.delete();
    seen_head = 0;
    #1;
    check("midrst_out_valid", OW'(out_valid), '0);
    check("midrst_out_data", out_data, '0);
    check("midrst_in_ready", OW'(in_ready), OW'(1));
    ready_mode = 0;
    send(64'hA000_0000_0000_0001, 2, 1'b1);
    idle(3);

    // Randomized traffic with backpressure and bubbles
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: sh = $urandom_range(0, 66);
        6:                sh = -$urandom_range(1, 4);
        7:                sh = $urandom_range(60, 127);
        8:                sh = -$urandom_range(1, 128);
        default:          sh = $urandom_range(0, 3);
      endcase
      m = {$urandom, $urandom};
      m[MW-1] = 1'b1;
      if (sh >= 1 && sh <= 64 && $urandom_range(0, 3) == 0) begin
        mask = (sh == 64) ? '1 : ((one << sh) - one);
        m    = (m & ~mask) | (one << (sh - 1));
      end
      if ($urandom_range(0, 9) == 0) m = '0;
      send(m, sh, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    ready_mode = 0;
    k = 0;
    while (sb.size() > 0 && k < 100) begin
      idle(1);
      k++;
    end
    idle(1);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d beats still pending, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
